// File: rtl/tawas_au_seq_pkg.sv
// tawas_au_seq_pkg
// Shared AU op-field definitions (tawas_au_defs) for the AU and its
// load-constant sequencer: op prefixes, field widths, step codes and
// helpers that assemble the 15-bit LD / ADDI / SHL encodings.
// Field layout:
//   LD   = {2'b11, imm9, 1'b0, reg}
//   ADDI = {3'b011, imm8, 1'b0, reg}
//   SHL  = {3'b010, 3'd4, shamt5, 1'b0, reg}
package tawas_au_seq_pkg;

  localparam int OP_W   = 15;
  localparam int REM_W  = 23;
  localparam int STEP_W = 4;
  localparam int NSLICE = 4;

  localparam logic [1:0] LD_PFX   = 2'b11;
  localparam logic [2:0] ADDI_PFX = 3'b011;
  localparam logic [2:0] SHL_PFX  = 3'b010;
  localparam logic [2:0] SHL_SUB  = 3'd4;

  // First step of a long-form constant; counts down to 1, 0 means idle.
  localparam logic [STEP_W-1:0] STEP_LONG = 4'd8;

  typedef logic [OP_W-1:0] au_op_t;

  typedef enum logic [1:0] {
    KIND_NONE,
    KIND_SHL,
    KIND_ADDI
  } step_kind_e;

  function automatic au_op_t mkLd(input logic [8:0] imm9, input logic [2:0] rd);
    return {LD_PFX, imm9, 1'b0, rd};
  endfunction

  function automatic au_op_t mkAddi(input logic [7:0] imm8, input logic [2:0] rd);
    return {ADDI_PFX, imm8, 1'b0, rd};
  endfunction

  function automatic au_op_t mkShl(input logic [4:0] shamt, input logic [2:0] rd);
    return {SHL_PFX, SHL_SUB, shamt, 1'b0, rd};
  endfunction

  // A constant fits a single LD when bits 31:8 are a sign extension of bit 8.
  function automatic logic isShortLdc(input logic [31:0] val);
    return val[31:8] == {24{val[8]}};
  endfunction

endpackage

// File: rtl/tawas_au_seq_if.sv
// tawas_au_seq_if
// Issue-slot bus between the thread scheduler (master) and the AU
// load-constant sequencer (slave).
//   slice              current issue slot, rotates 0..3
//   in_op_vld/in_op    normal AU op offered by the slot
//   ldc_vld/reg/val    load-constant macro request
//   flush_vld/slice    abort a slice's running sequence
//   au_op_vld/au_op    op sent to the AU for the current slot
//   slice_stall        offered op not consumed, replay next slot
//   seq_busy           per-slice sequence active
interface tawas_au_seq_if;
  import tawas_au_seq_pkg::*;

  logic [1:0]        slice;
  logic              in_op_vld;
  au_op_t            in_op;
  logic              ldc_vld;
  logic [2:0]        ldc_reg;
  logic [31:0]       ldc_val;
  logic              flush_vld;
  logic [1:0]        flush_slice;
  logic              au_op_vld;
  au_op_t            au_op;
  logic              slice_stall;
  logic [NSLICE-1:0] seq_busy;

  modport master (
    output slice, in_op_vld, in_op, ldc_vld, ldc_reg, ldc_val,
           flush_vld, flush_slice,
    input  au_op_vld, au_op, slice_stall, seq_busy
  );

  modport slave (
    input  slice, in_op_vld, in_op, ldc_vld, ldc_reg, ldc_val,
           flush_vld, flush_slice,
    output au_op_vld, au_op, slice_stall, seq_busy
  );

endinterface

// File: rtl/tawas_au_seq_ldc_step.sv
// tawas_ldc_step
// Purely combinational: maps a long-form step number, the target
// register and the remaining 23 value bits to the AU op for that step.
// Even steps shift the partial result left, odd steps add in the next
// chunk of value bits, so after step 1 the register holds the constant.
//   i_step  step counter (8..1 active, others give op 0)
//   i_reg   destination register
//   i_val   remaining value bits v[22:0]
//   o_op    15-bit AU op
module tawas_ldc_step
  import tawas_au_seq_pkg::*;
(
  input  logic [STEP_W-1:0] i_step,
  input  logic [2:0]        i_reg,
  input  logic [REM_W-1:0]  i_val,
  output au_op_t            o_op
);

  step_kind_e w_kind;
  logic [4:0] w_shamt;
  logic [7:0] w_imm;

  // Decode the step into an op kind plus its shift amount or immediate.
  always_comb begin
    w_kind  = KIND_NONE;
    w_shamt = '0;
    w_imm   = '0;
    case (i_step)
      4'd8, 4'd6, 4'd4: begin w_kind = KIND_SHL;  w_shamt = 5'd7; end
      4'd2:             begin w_kind = KIND_SHL;  w_shamt = 5'd2; end
      4'd7:             begin w_kind = KIND_ADDI; w_imm = {1'b0, i_val[22:16]}; end
      4'd5:             begin w_kind = KIND_ADDI; w_imm = {1'b0, i_val[15:9]}; end
      4'd3:             begin w_kind = KIND_ADDI; w_imm = {1'b0, i_val[8:2]}; end
      4'd1:             begin w_kind = KIND_ADDI; w_imm = {6'b0, i_val[1:0]}; end
      default:          ;
    endcase
  end

  // Assemble the encoding for the decoded kind.
  always_comb begin
    case (w_kind)
      KIND_SHL:  o_op = mkShl(w_shamt, i_reg);
      KIND_ADDI: o_op = mkAddi(w_imm, i_reg);
      default:   o_op = '0;
    endcase
  end

endmodule

// File: rtl/tawas_au_seq.sv
// tawas_au_seq
// Expands load-constant macros into AU ops. A constant that fits a
// sign-extended 9-bit immediate becomes one LD; anything else becomes
// LD of the top 9 bits followed by 8 shift/add steps issued in the
// same slice's later slots. While a slice is sequencing its offered
// op is stalled so the scheduler replays it.
//   clk, rst  clock and asynchronous active-high reset
//   bus       slave side of tawas_au_seq_if
module tawas_au_seq
  import tawas_au_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  tawas_au_seq_if.slave  bus
);

  logic [STEP_W-1:0] r_step [NSLICE];
  logic [2:0]        r_reg  [NSLICE];
  logic [REM_W-1:0]  r_val  [NSLICE];

  logic   w_busy;
  logic   w_short;
  logic   w_flushHere;
  au_op_t w_stepOp;

  assign w_busy      = r_step[bus.slice] != '0;
  assign w_short     = isShortLdc(bus.ldc_val);
  assign w_flushHere = bus.flush_vld && (bus.flush_slice == bus.slice);

  tawas_ldc_step u_step (
    .i_step (r_step[bus.slice]),
    .i_reg  (r_reg[bus.slice]),
    .i_val  (r_val[bus.slice]),
    .o_op   (w_stepOp)
  );

  // Slot output mux. During reset only the normal op passes; a pending
  // ldc is stalled so it gets replayed once the block is out of reset.
  // A flush aimed at the busy current slot suppresses its step op.
  always_comb begin
    bus.au_op       = bus.in_op;
    bus.au_op_vld   = bus.in_op_vld;
    bus.slice_stall = 1'b0;
    if (rst) begin
      bus.slice_stall = bus.ldc_vld;
    end else if (w_busy) begin
      bus.au_op       = w_stepOp;
      bus.au_op_vld   = !w_flushHere;
      bus.slice_stall = 1'b1;
    end else if (bus.ldc_vld) begin
      bus.au_op       = mkLd(w_short ? bus.ldc_val[8:0] : bus.ldc_val[31:23], bus.ldc_reg);
      bus.au_op_vld   = 1'b1;
      bus.slice_stall = !w_short || bus.in_op_vld;
    end
  end

  always_comb begin
    for (int s = 0; s < NSLICE; s++) begin
      bus.seq_busy[s] = r_step[s] != '0;
    end
  end

  // Per-slice sequencing state. A slice only advances in its own slot;
  // a flush may clear any busy slice, and wins over the slot update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NSLICE; s++) begin
        r_step[s] <= '0;
        r_reg[s]  <= '0;
        r_val[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < NSLICE; s++) begin
        if (2'(s) == bus.slice) begin
          if (r_step[s] != '0) begin
            r_step[s] <= r_step[s] - 1'b1;
          end else if (bus.ldc_vld && !w_short) begin
            r_step[s] <= STEP_LONG;
            r_reg[s]  <= bus.ldc_reg;
            r_val[s]  <= bus.ldc_val[REM_W-1:0];
          end
        end
        if (bus.flush_vld && (bus.flush_slice == 2'(s)) && (r_step[s] != '0)) begin
          r_step[s] <= '0;
        end
      end
    end
  end

endmodule
